lcd_cmd_sequencer: RTL and testbench
====================================

Name: lcd_cmd_sequencer

Overview:
- Drives the LCD write-cycle engine: runs the HD44780 power-on init sequence, then accepts user command/data bytes over a valid/ready handshake.
- Issues one write-cycle request per byte, holds the DB/RS lines stable across the cycle, and enforces the controller execution delay before the next byte.
- Sits between the application logic (text/command source) and the E-pulse write-cycle block.

Parameters:
- T_POWERUP, 750000, clk cycles to wait after reset before the first init command (15 ms at 50 MHz).
- T_CMD, 2000, clk cycles to wait after a normal command or data write (40 us).
- T_CLEAR, 82000, clk cycles to wait after Clear Display (0x01) or Return Home (0x02/0x03) (1.64 ms).
- CNT_W, 20, delay counter width; must hold max(T_POWERUP, T_CLEAR).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  user byte available
- cmd_rs  in  1  0 = instruction, 1 = data (DDRAM/CGRAM)
- cmd_data  in  8  user byte
- cmd_ready  out  1  sequencer can accept a user byte this cycle
- init_done  out  1  init sequence complete (sticky until reset)
- wr_enable  out  1  single-cycle start pulse to the write-cycle engine
- wr_finish  in  1  single-cycle completion pulse from the write-cycle engine
- reg_sel  out  1  RS value for the write-cycle engine
- db_out  out  8  LCD DB[7:0]

Behaviour:
- Reset values: cmd_ready=0, init_done=0, wr_enable=0, reg_sel=0, db_out=8'h00, state=PWRUP, counter=0, init index=0. Reset mid-operation aborts immediately; no completion of the pending write.
- All outputs are registered. wr_enable is high for exactly 1 cycle per write and is never high while a write is outstanding.
- States:
  - PWRUP: count T_POWERUP cycles, then go to INIT_WR.
  - INIT_WR: load db_out=INIT_ROM[idx], reg_sel=0, pulse wr_enable, go to INIT_BUSY.
  - INIT_BUSY: wait for wr_finish, then go to INIT_WAIT.
  - INIT_WAIT: count T_CMD, or T_CLEAR when the byte was 0x01. Then idx++ and go to INIT_WR; after idx=3, set init_done=1 and go to IDLE.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, capture cmd_rs/cmd_data into reg_sel/db_out, drop cmd_ready the next cycle, go to USR_WR.
  - USR_WR: pulse wr_enable, go to USR_BUSY.
  - USR_BUSY: wait for wr_finish, then go to USR_WAIT.
  - USR_WAIT: count the delay, then go to IDLE.
- INIT_ROM: 0x38 (8-bit, 2 line, 5x8), 0x0C (display on, cursor off), 0x06 (entry increment), 0x01 (clear).
- Delay select for user bytes: T_CLEAR if cmd_rs=0 and cmd_data ∈ {0x01, 0x02, 0x03}; otherwise T_CMD. Data writes always use T_CMD.
- Delay definition: if wr_finish is sampled high in cycle n, the next wr_enable (or cmd_ready=1) occurs in cycle n+1+T. PWRUP: first wr_enable at cycle T_POWERUP+1 after reset release.
- reg_sel and db_out stay stable from the wr_enable cycle until the delay expires. They change only at capture/load.
- cmd_ready is 0 in every state except IDLE. cmd_valid in other states is ignored (not captured, no error).
- Spurious wr_finish outside *_BUSY is ignored. There is no timeout: the block waits in BUSY indefinitely.
- Counter counts up from 0 and compares against T-1. It is cleared on every state entry and never wraps.

Decomposition:
- Package lcd_pkg holds:
  - state enum;
  - INIT_ROM contents and length (4);
  - instruction constants: CLEAR=0x01, HOME=0x02, ENTRY=0x06, DISP_ON=0x0C, FUNC_SET=0x38.
- One natural sub-module: lcd_delay_timer (load value, start, done pulse), shared by the PWRUP, INIT_WAIT and USR_WAIT states.

Test Plan (T_POWERUP=20, T_CMD=5, T_CLEAR=12; bench models write_cycle with wr_finish 3 cycles after wr_enable):
- Reset release -> first wr_enable at cycle 21 with db_out=0x38, reg_sel=0. Writes then follow in order 0x38, 0x0C, 0x06, 0x01. After 0x01 the gap is 12 cycles; init_done and cmd_ready rise together.
- After init, cmd_valid with rs=1, data=0x41 -> accepted in 1 cycle. Single wr_enable pulse with db_out=0x41, reg_sel=1. cmd_ready returns exactly 6 cycles after wr_finish.
- User instruction 0x01 (rs=0) -> cmd_ready returns 13 cycles after wr_finish. Instruction 0x80 -> 6 cycles.
- cmd_valid held high during init and during USR_WAIT -> no capture. db_out stays unchanged until IDLE.
- Assert rst during USR_BUSY -> all outputs return to reset values at once. The init sequence restarts with a 20-cycle wait.
- Inject wr_finish while in IDLE -> no state change and no wr_enable.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD command sequencer: FSM states,
// HD44780 instruction codes and the power-on init byte table.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP     = 3'd0,
    INIT_WR   = 3'd1,
    INIT_BUSY = 3'd2,
    INIT_WAIT = 3'd3,
    IDLE      = 3'd4,
    USR_WR    = 3'd5,
    USR_BUSY  = 3'd6,
    USR_WAIT  = 3'd7
  } seq_state_e;

  // HD44780 instruction codes used by the init sequence and delay selection
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] HOME     = 8'h02;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] FUNC_SET = 8'h38;

  // Power-on init table: 8-bit/2-line/5x8, display on, entry increment, clear
  localparam int INIT_LEN = 4;
  localparam int IDX_W    = 2;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{FUNC_SET, DISP_ON, ENTRY, CLEAR};

  // Clear Display and Return Home (0x02/0x03) need the long execution delay
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CLEAR) || (data == HOME) || (data == 8'h03));
  endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// Command channel from the application plus the write-cycle engine channel.
// The sequencer uses the slave view; the application/engine side uses master.
interface lcd_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       init_done;
  logic       wr_enable;
  logic       wr_finish;
  logic       reg_sel;
  logic [7:0] db_out;

  modport slave (
    input  cmd_valid, cmd_rs, cmd_data, wr_finish,
    output cmd_ready, init_done, wr_enable, reg_sel, db_out
  );

  modport master (
    output cmd_valid, cmd_rs, cmd_data, wr_finish,
    input  cmd_ready, init_done, wr_enable, reg_sel, db_out
  );
endinterface

// File: rtl/lcd_delay_timer.sv
// Up-counting delay timer. A start pulse clears the count and latches the
// delay length; done is high in the cycle the count reaches length-1.
// The counter saturates instead of wrapping so a stale done cannot recur.
module lcd_delay_timer #(
  parameter int CNT_W    = 20,
  parameter int RST_LOAD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit_q, limit_d;

  // Next count: restart on start, otherwise count up and hold at all-ones
  always_comb begin
    cnt_d   = cnt_q;
    limit_d = limit_q;
    if (start) begin
      cnt_d   = '0;
      limit_d = load_val;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and latched length registers; reset arms the power-up delay
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      limit_q <= CNT_W'(RST_LOAD);
    end else begin
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
    end
  end

  assign done = (cnt_q == (limit_q - 1'b1));

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// HD44780 command sequencer: runs the power-on init table, then forwards
// user bytes to the write-cycle engine one at a time, holding DB/RS stable
// and enforcing the controller execution delay after every write.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int T_POWERUP = 750000,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int CNT_W     = 20
) (
  input  logic                clk,
  input  logic                rst,
  lcd_cmd_sequencer_if.slave  bus
);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             slow_q, slow_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             init_done_q, init_done_d;
  logic             wr_enable_q, wr_enable_d;
  logic             reg_sel_q, reg_sel_d;
  logic [7:0]       db_out_q, db_out_d;

  logic             tmr_start;
  logic [CNT_W-1:0] tmr_load;
  logic             tmr_done;
  logic             accept;

  // cmd_ready_q is only ever high in IDLE, so this is the handshake itself
  assign accept = cmd_ready_q && bus.cmd_valid;

  lcd_delay_timer #(
    .CNT_W    (CNT_W),
    .RST_LOAD (T_POWERUP)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .start    (tmr_start),
    .load_val (tmr_load),
    .done     (tmr_done)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    slow_d      = slow_q;
    cmd_ready_d = 1'b0;
    init_done_d = init_done_q;
    wr_enable_d = 1'b0;
    reg_sel_d   = reg_sel_q;
    db_out_d    = db_out_q;

    case (state_q)
      PWRUP: begin
        if (tmr_done) state_d = INIT_WR;
      end
      INIT_WR: begin
        db_out_d    = INIT_ROM[idx_q];
        reg_sel_d   = 1'b0;
        wr_enable_d = 1'b1;
        state_d     = INIT_BUSY;
      end
      INIT_BUSY: begin
        if (bus.wr_finish) state_d = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (tmr_done) begin
          if (idx_q == IDX_W'(INIT_LEN - 1)) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = INIT_WR;
          end
        end
      end
      IDLE: begin
        // ready and init_done rise one cycle after entering IDLE so the
        // delay counts T whole cycles after the finish pulse
        init_done_d = 1'b1;
        if (accept) begin
          reg_sel_d = bus.cmd_rs;
          db_out_d  = bus.cmd_data;
          slow_d    = is_slow_cmd(bus.cmd_rs, bus.cmd_data);
          state_d   = USR_WR;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      USR_WR: begin
        wr_enable_d = 1'b1;
        state_d     = USR_BUSY;
      end
      USR_BUSY: begin
        if (bus.wr_finish) state_d = USR_WAIT;
      end
      USR_WAIT: begin
        if (tmr_done) state_d = IDLE;
      end
      default: state_d = PWRUP;
    endcase
  end

  // Restart the timer on every state change with the delay of the new state
  always_comb begin
    tmr_start = (state_d != state_q);
    tmr_load  = CNT_W'(T_CMD);
    case (state_d)
      PWRUP:     tmr_load = CNT_W'(T_POWERUP);
      INIT_WAIT: tmr_load = (INIT_ROM[idx_q] == CLEAR) ? CNT_W'(T_CLEAR) : CNT_W'(T_CMD);
      USR_WAIT:  tmr_load = slow_q ? CNT_W'(T_CLEAR) : CNT_W'(T_CMD);
      default:   tmr_load = CNT_W'(T_CMD);
    endcase
  end

  // State and output registers; reset aborts any write in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PWRUP;
      idx_q       <= '0;
      slow_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      wr_enable_q <= 1'b0;
      reg_sel_q   <= 1'b0;
      db_out_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      slow_q      <= slow_d;
      cmd_ready_q <= cmd_ready_d;
      init_done_q <= init_done_d;
      wr_enable_q <= wr_enable_d;
      reg_sel_q   <= reg_sel_d;
      db_out_q    <= db_out_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.init_done = init_done_q;
  assign bus.wr_enable = wr_enable_q;
  assign bus.reg_sel   = reg_sel_q;
  assign bus.db_out    = db_out_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Scoreboard bench for lcd_cmd_sequencer with a modelled write-cycle engine
// (wr_finish sampled 3 cycles after wr_enable).
module tb_lcd_cmd_sequencer;

  localparam int T_PU = 20;
  localparam int T_C  = 5;
  localparam int T_CL = 12;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    bit         rel;   // 1: val is a delay after the last finish; 0: val is an absolute cycle
    int         val;
  } wr_exp_t;

  logic clk;
  logic rst;
  logic eng_fin;
  logic spur_fin;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rel_cyc  = 0;
  int last_fin = 0;
  bit fin_valid = 0;
  bit eng_pending = 0;
  int eng_due  = 0;
  bit rdy_prev = 0;
  int wr_count = 0;
  logic [7:0] last_db = 8'h00;

  wr_exp_t exp_wr[$];
  int      exp_rdy[$];

  lcd_cmd_sequencer_if bus();

  lcd_cmd_sequencer #(
    .T_POWERUP (T_PU),
    .T_CMD     (T_C),
    .T_CLEAR   (T_CL),
    .CNT_W     (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.wr_finish = eng_fin | spur_fin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (cyc=%0d)", name, act, req, cyc);
    end
  endtask

  // Engine model and monitor: pops expected writes / ready rises and compares
  always @(negedge clk) begin
    if (rst) begin
      eng_pending = 0;
      eng_fin     = 1'b0;
      fin_valid   = 0;
      rdy_prev    = 0;
    end else begin
      if (eng_fin) begin
        eng_fin   = 1'b0;
        last_fin  = cyc;
        fin_valid = 1;
      end
      if (eng_pending && cyc == eng_due) begin
        eng_fin     = 1'b1;
        eng_pending = 0;
      end
      if (bus.wr_enable) begin
        int base;
        int exp_cyc;
        wr_exp_t e;
        wr_count++;
        chk("wr_while_outstanding", int'(eng_pending || eng_fin), 0);
        eng_pending = 1;
        eng_due     = cyc + 2;
        $display("write cyc=%0d rs=%0b db=%02h", cyc, bus.reg_sel, bus.db_out);
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write db_out=%02h reg_sel=%0b required=none", bus.db_out, bus.reg_sel);
        end else begin
          e = exp_wr.pop_front();
          base = fin_valid ? last_fin : rel_cyc;
          exp_cyc = e.rel ? (base + 1 + e.val) : e.val;
          chk("wr_db_out", int'(bus.db_out), int'(e.data));
          chk("wr_reg_sel", int'(bus.reg_sel), int'(e.rs));
          chk("wr_cycle", cyc, exp_cyc);
        end
        last_db = bus.db_out;
      end
      if (bus.cmd_ready && !rdy_prev) begin
        $display("ready cyc=%0d init_done=%0b db=%02h", cyc, bus.init_done, bus.db_out);
        if (exp_rdy.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready cyc=%0d required=none", cyc);
        end else begin
          int gap;
          gap = exp_rdy.pop_front();
          chk("ready_cycle", cyc, (fin_valid ? last_fin : rel_cyc) + 1 + gap);
          chk("ready_init_done", int'(bus.init_done), 1);
          chk("ready_db_stable", int'(bus.db_out), int'(last_db));
        end
      end
      rdy_prev = bus.cmd_ready;
    end
  end

  task automatic push_init();
    exp_wr.push_back('{rs: 1'b0, data: 8'h38, rel: 1'b1, val: T_PU});
    exp_wr.push_back('{rs: 1'b0, data: 8'h0C, rel: 1'b1, val: T_C});
    exp_wr.push_back('{rs: 1'b0, data: 8'h06, rel: 1'b1, val: T_C});
    exp_wr.push_back('{rs: 1'b0, data: 8'h01, rel: 1'b1, val: T_C});
    exp_rdy.push_back(T_CL);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, int'(bus.cmd_ready), 0);
    chk({tag, "_init_done"}, int'(bus.init_done), 0);
    chk({tag, "_wr_enable"}, int'(bus.wr_enable), 0);
    chk({tag, "_reg_sel"},   int'(bus.reg_sel), 0);
    chk({tag, "_db_out"},    int'(bus.db_out), 0);
  endtask

  task automatic wait_ready();
    bit seen;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (bus.cmd_ready) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout cmd_ready=%0b required=1", bus.cmd_ready);
    end
  endtask

  // Present one byte while cmd_ready is high; it is accepted on the next edge
  task automatic send(input logic rs, input logic [7:0] data, input int gap, input bit exp_ready);
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = rs;
    bus.cmd_data  = data;
    exp_wr.push_back('{rs: rs, data: data, rel: 1'b0, val: cyc + 2});
    if (exp_ready) exp_rdy.push_back(gap);
    @(negedge clk); #1;
    chk("accept_ready_drop", int'(bus.cmd_ready), 0);
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    spur_fin      = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_rs    = 1'b0;
    bus.cmd_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("reset");

    // Init sequence with a byte offered the whole time (must be ignored)
    push_init();
    rst     = 1'b0;
    rel_cyc = cyc;
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = 1'b1;
    bus.cmd_data  = 8'hA5;
    for (int i = 0; i < 300 && wr_count < 4; i++) begin
      @(negedge clk); #1;
    end
    chk("init_write_count", wr_count, 4);
    bus.cmd_valid = 1'b0;

    // Data byte, short delay
    wait_ready();
    send(1'b1, 8'h41, T_C, 1);

    // Clear instruction, long delay
    wait_ready();
    send(1'b0, 8'h01, T_CL, 1);

    // Set DDRAM address, short delay; offer a byte during USR_WAIT
    wait_ready();
    send(1'b0, 8'h80, T_C, 1);
    repeat (5) begin @(negedge clk); #1; end
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = 1'b1;
    bus.cmd_data  = 8'h99;
    repeat (3) begin @(negedge clk); #1; end
    bus.cmd_valid = 1'b0;

    // Spurious finish in IDLE must be ignored
    wait_ready();
    spur_fin = 1'b1;
    @(negedge clk); #1;
    spur_fin = 1'b0;
    repeat (4) begin @(negedge clk); #1; end
    chk("idle_after_spurious_finish", int'(bus.cmd_ready), 1);

    // Reset while the write is outstanding
    send(1'b1, 8'h42, T_C, 0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("busy_db_out", int'(bus.db_out), 8'h42);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (2) begin @(negedge clk); #1; end
    push_init();
    rst     = 1'b0;
    rel_cyc = cyc;
    wait_ready();
    repeat (10) begin @(negedge clk); #1; end
    chk("exp_wr_empty", exp_wr.size(), 0);
    chk("exp_rdy_empty", exp_rdy.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
